// File: rtl/lru_cache_rd.sv
// lru_cache_rd: fully-associative read-only line cache with true-LRU replacement, AXI4 read front/back ends.
// Define LRU_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module lru_cache_rd #(
  parameter int NUM_WAYS      = 8,
  parameter int LINE_BYTES    = 64,
  parameter int ADDR_WIDTH    = 48,
  parameter int FE_DATA_WIDTH = 64,
  parameter int FE_ID_WIDTH   = 1,
  parameter int BE_DATA_WIDTH = 512
) (
  input  logic                     clk,
  input  logic                     rstn,
`ifdef LRU_CACHE_STATS_EN
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt,
`endif
  input  logic                     flush,
  input  logic                     fe_arvalid,
  output logic                     fe_arready,
  input  logic [ADDR_WIDTH-1:0]    fe_araddr,
  input  logic [FE_ID_WIDTH-1:0]   fe_arid,
  output logic                     fe_rvalid,
  input  logic                     fe_rready,
  output logic [FE_DATA_WIDTH-1:0] fe_rdata,
  output logic [FE_ID_WIDTH-1:0]   fe_rid,
  output logic [1:0]               fe_rresp,
  output logic                     fe_rlast,
  output logic                     be_arvalid,
  input  logic                     be_arready,
  output logic [ADDR_WIDTH-1:0]    be_araddr,
  output logic [7:0]               be_arlen,
  output logic [2:0]               be_arsize,
  output logic [1:0]               be_arburst,
  input  logic                     be_rvalid,
  output logic                     be_rready,
  input  logic [BE_DATA_WIDTH-1:0] be_rdata,
  input  logic [1:0]               be_rresp,
  input  logic                     be_rlast
);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int TAG_W  = ADDR_WIDTH - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BEATS  = LINE_W / BE_DATA_WIDTH;
  localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WSEL   = $clog2(FE_DATA_WIDTH / 8);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_BE_AR = 3'd2, S_BE_R = 3'd3, S_RESP = 3'd4;
  logic [2:0]              state;
  logic [TAG_W-1:0]        tag;
  logic [OFF_W-1:0]        off;
  logic [FE_ID_WIDTH-1:0]  id;
  logic [NUM_WAYS-1:0]     vld;
  logic [TAG_W-1:0]        tags  [NUM_WAYS];
  logic [LINE_W-1:0]       lines [NUM_WAYS];
  logic [WAY_W-1:0]        age   [NUM_WAYS];
  logic [LINE_W-1:0]       fill, fill_nx;
  logic [BEAT_W-1:0]       beat;
  logic                    err, err_nx, last, hit, inst, upd;
  logic [WAY_W-1:0]        hit_way, vic, upd_way;
  function automatic logic [FE_DATA_WIDTH-1:0] sel(input logic [LINE_W-1:0] l, input logic [OFF_W-1:0] o);
    return l[32'(o >> WSEL) * FE_DATA_WIDTH +: FE_DATA_WIDTH];
  endfunction
  assign fe_arready = rstn && state == S_IDLE && !flush;
  assign fe_rvalid  = state == S_RESP;
  assign fe_rid     = id;
  assign fe_rlast   = 1'b1;
  assign be_arvalid = state == S_BE_AR;
  assign be_rready  = state == S_BE_R;
  assign be_araddr  = {tag, {OFF_W{1'b0}}};
  assign be_arlen   = 8'(BEATS - 1);
  assign be_arsize  = 3'($clog2(BE_DATA_WIDTH / 8));
  assign be_arburst = 2'b01;
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    vic = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (vld[i] && tags[i] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(i);
      end
    // descending scan so the lowest-index invalid way wins, overriding the oldest way
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (age[i] == WAY_W'(NUM_WAYS - 1)) vic = WAY_W'(i);
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!vld[i]) vic = WAY_W'(i);
    fill_nx = fill;
    fill_nx[32'(beat) * BE_DATA_WIDTH +: BE_DATA_WIDTH] = be_rdata;
    last    = be_rvalid && beat == BEAT_W'(BEATS - 1);
    err_nx  = err || be_rresp != 2'b00;
    inst    = state == S_BE_R && last && !err_nx;
    upd     = (state == S_LOOKUP && hit) || inst;
    upd_way = state == S_LOOKUP ? hit_way : vic;
  end
  always_ff @(posedge clk) begin
    if (state == S_BE_R && be_rvalid) fill <= fill_nx;
    if (inst) begin
      tags[vic]  <= tag;
      lines[vic] <= fill_nx;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= S_IDLE;
      tag      <= '0;
      off      <= '0;
      id       <= '0;
      vld      <= '0;
      beat     <= '0;
      err      <= 1'b0;
      fe_rdata <= '0;
      fe_rresp <= 2'b00;
      for (int i = 0; i < NUM_WAYS; i++) age[i] <= WAY_W'(i);
    end else begin
      if (upd) begin
        for (int i = 0; i < NUM_WAYS; i++)
          if (age[i] < age[upd_way]) age[i] <= age[i] + WAY_W'(1);
        age[upd_way] <= '0;
      end
      case (state)
        S_IDLE:
          if (flush) begin
            vld <= '0;
            for (int i = 0; i < NUM_WAYS; i++) age[i] <= WAY_W'(i);
          end else if (fe_arvalid) begin
            tag   <= fe_araddr[ADDR_WIDTH-1:OFF_W];
            off   <= fe_araddr[OFF_W-1:0];
            id    <= fe_arid;
            state <= S_LOOKUP;
          end
        S_LOOKUP: begin
          beat     <= '0;
          err      <= 1'b0;
          fe_rdata <= sel(lines[hit_way], off);
          fe_rresp <= 2'b00;
          state    <= hit ? S_RESP : S_BE_AR;
        end
        S_BE_AR: if (be_arready) state <= S_BE_R;
        S_BE_R:
          if (be_rvalid) begin
            beat <= beat + BEAT_W'(1);
            err  <= err_nx;
            if (last) begin
              fe_rdata <= sel(fill_nx, off);
              fe_rresp <= err_nx ? 2'b10 : 2'b00;
              state    <= S_RESP;
              if (!err_nx) vld[vic] <= 1'b1;
            end
          end
        S_RESP: if (fe_rready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
`ifdef LRU_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 32'd1;
      if (!hit && !(&miss_cnt)) miss_cnt <= miss_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_lru_cache_rd.sv
// tb_lru_cache_rd: randomized scoreboard bench; reference model keeps resident lines as an MRU-first queue.
module tb_lru_cache_rd;
  logic clk = 0, rstn = 0, flush = 0;
  logic fe_arvalid = 0, fe_arready, fe_rvalid, fe_rready = 0, fe_rlast;
  logic [47:0] fe_araddr = '0;
  logic [0:0] fe_arid = '0, fe_rid;
  logic [63:0] fe_rdata;
  logic [1:0] fe_rresp;
  logic be_arvalid, be_arready, be_rvalid, be_rready, be_rlast;
  logic [47:0] be_araddr;
  logic [7:0] be_arlen;
  logic [2:0] be_arsize;
  logic [1:0] be_arburst, be_rresp;
  logic [511:0] be_rdata;
  always #5 clk = ~clk;
  lru_cache_rd dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .fe_arvalid(fe_arvalid), .fe_arready(fe_arready), .fe_araddr(fe_araddr), .fe_arid(fe_arid),
    .fe_rvalid(fe_rvalid), .fe_rready(fe_rready), .fe_rdata(fe_rdata), .fe_rid(fe_rid),
    .fe_rresp(fe_rresp), .fe_rlast(fe_rlast),
    .be_arvalid(be_arvalid), .be_arready(be_arready), .be_araddr(be_araddr), .be_arlen(be_arlen),
    .be_arsize(be_arsize), .be_arburst(be_arburst), .be_rvalid(be_rvalid), .be_rready(be_rready),
    .be_rdata(be_rdata), .be_rresp(be_rresp), .be_rlast(be_rlast)
  );
  typedef struct packed {
    logic [63:0] d;
    logic [0:0]  id;
    logic [1:0]  r;
    int          nar;
  } exp_t;
  exp_t sbq[$];
  logic [47:0] exp_ar[$];
  logic [41:0] lru[$];
  int total = 0, pass = 0, n_ar = 0, exp_nar = 0;
  logic be_err = 0, be_hang = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  function automatic logic [63:0] wd(logic [41:0] t, int k);
    return ({22'd0, t} * 64'h9E37_79B9_7F4A_7C15) ^ 64'(k);
  endfunction
  task automatic model(input logic [47:0] a, input logic [0:0] i, input logic e, output logic h);
    logic [41:0] t;
    exp_t x;
    t = a[47:6];
    h = 0;
    foreach (lru[k])
      if (!h && lru[k] == t) begin
        h = 1;
        lru.delete(k);
      end
    if (h) lru.push_front(t);
    else begin
      exp_nar++;
      exp_ar.push_back({t, 6'd0});
      if (!e) begin
        if (lru.size() == 8) void'(lru.pop_back());
        lru.push_front(t);
      end
    end
    x.d = wd(t, int'(a[5:3]));
    x.id = i;
    x.r = (!h && e) ? 2'b10 : 2'b00;
    x.nar = exp_nar;
    sbq.push_back(x);
  endtask
  task automatic chk_rst();
    chk("rst_arready", 64'(fe_arready), 0);
    chk("rst_rvalid", 64'(fe_rvalid), 0);
    chk("rst_rdata", fe_rdata, 0);
    chk("rst_rid", 64'(fe_rid), 0);
    chk("rst_rresp", 64'(fe_rresp), 0);
    chk("rst_rlast", 64'(fe_rlast), 1);
    chk("rst_be_arvalid", 64'(be_arvalid), 0);
    chk("rst_be_araddr", 64'(be_araddr), 0);
    chk("rst_be_arlen", 64'(be_arlen), 0);
    chk("rst_be_arsize", 64'(be_arsize), 6);
    chk("rst_be_arburst", 64'(be_arburst), 1);
    chk("rst_be_rready", 64'(be_rready), 0);
  endtask
  task automatic issue(input logic [47:0] a, input logic [0:0] i, input logic rr);
    int n;
    @(posedge clk); #1;
    fe_arvalid = 1; fe_araddr = a; fe_arid = i; fe_rready = rr;
    n = 0;
    @(negedge clk);
    while (!fe_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", 64'(fe_arready), 1);
    @(posedge clk); #1;
    fe_arvalid = 0;
  endtask
  task automatic rd(input logic [47:0] a, input logic e, input int dly, input logic fl);
    logic h;
    logic [0:0] i;
    int n;
    i = 1'($urandom);
    model(a, i, e, h);
    be_err = e;
    issue(a, i, dly == 0);
    if (fl) flush = 1;
    if (h) begin
      @(negedge clk) chk("lat_lookup", 64'(fe_rvalid), 0);
      @(negedge clk) chk("lat_hit", 64'(fe_rvalid), 1);
    end
    n = 0;
    while (!fe_rvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resp_arrives", 64'(fe_rvalid), 1);
    if (dly > 0) begin
      repeat (dly) @(posedge clk);
      #1 fe_rready = 1;
    end
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_done", 64'(sbq.size()), 0);
    sbq.delete();
    @(posedge clk); #1 fe_rready = 0;
    if (fl) begin
      @(posedge clk); #1 flush = 0;
      lru.delete();
    end
  endtask
  task automatic do_flush();
    @(posedge clk); #1 flush = 1;
    @(negedge clk) chk("flush_arready", 64'(fe_arready), 0);
    @(posedge clk); #1 flush = 0;
    lru.delete();
  endtask
  always @(negedge clk)
    if (rstn && fe_rvalid) begin
      if (sbq.size() == 0) chk("unexpected_resp", 64'(fe_rvalid), 0);
      else begin
        if (sbq[0].r == 2'b00) chk("rdata", fe_rdata, sbq[0].d);
        chk("rid", 64'(fe_rid), 64'(sbq[0].id));
        chk("rresp", 64'(fe_rresp), 64'(sbq[0].r));
        chk("rlast", 64'(fe_rlast), 1);
        chk("arready_in_resp", 64'(fe_arready), 0);
        chk("be_ar_count", 64'(n_ar), 64'(sbq[0].nar));
        if (fe_rready) void'(sbq.pop_front());
      end
    end
  initial begin
    int d;
    logic [47:0] a;
    be_arready = 0; be_rvalid = 0; be_rdata = '0; be_rresp = 0; be_rlast = 0;
    forever begin
      @(negedge clk);
      if (rstn && be_arvalid) begin
        d = $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        be_arready = 1;
        a = be_araddr;
        chk("be_arlen", 64'(be_arlen), 0);
        chk("be_arsize", 64'(be_arsize), 6);
        chk("be_arburst", 64'(be_arburst), 1);
        if (exp_ar.size() == 0) chk("unexpected_be_ar", 64'(be_arvalid), 0);
        else chk("be_araddr", 64'(a), 64'(exp_ar.pop_front()));
        @(posedge clk); #1 be_arready = 0;
        n_ar++;
        if (!be_hang) begin
          d = $urandom_range(0, 3);
          repeat (d) @(posedge clk);
          #1;
          for (int k = 0; k < 8; k++) be_rdata[k*64 +: 64] = wd(a[47:6], k);
          be_rresp = be_err ? 2'b10 : 2'b00;
          be_rvalid = 1; be_rlast = 1;
          @(posedge clk); #1 be_rvalid = 0; be_rlast = 0;
        end
      end
    end
  end
  initial begin
    int n;
    logic [47:0] a;
    #2 chk_rst();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    rd(48'h1000_0040, 0, 0, 0);
    rd(48'h1000_0048, 0, 0, 0);
    do_flush();
    for (int i = 0; i < 8; i++) rd(48'h2000_0000 + 48'(i * 64) + 48'(i * 8), 0, 0, 0);
    rd(48'h2000_0010, 0, 0, 0);
    rd(48'h2000_0200, 0, 0, 0);
    rd(48'h2000_0040, 0, 1, 0);
    rd(48'h2000_0038, 0, 0, 0);
    rd(48'h3000_0080, 1, 0, 0);
    rd(48'h3000_0088, 0, 0, 0);
    rd(48'h3000_0090, 0, 10, 0);
    do_flush();
    rd(48'h3000_0080, 0, 0, 0);
    rd(48'h2000_0000, 0, 2, 1);
    rd(48'h2000_0000, 0, 0, 0);
    a = 48'h4000_01C0;
    be_hang = 1;
    exp_nar++;
    exp_ar.push_back({a[47:6], 6'd0});
    issue(a, 1, 1);
    n = 0;
    while (!be_rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_be_r", 64'(be_rready), 1);
    #3 rstn = 0;
    #1 chk_rst();
    sbq.delete();
    lru.delete();
    @(posedge clk);
    @(posedge clk); #1 rstn = 1; be_hang = 0; fe_rready = 0;
    rd(a, 0, 0, 0);
    rd(48'h2000_0000, 0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      a = {6'h0A, 36'($urandom_range(0, 11)), 6'($urandom)};
      rd(a, $urandom_range(0, 9) == 0, $urandom_range(0, 3), $urandom_range(0, 24) == 0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
